// File: rtl/ex_stage_if.sv
// Handshake and datapath bundle between the decode side, the execute stage and the memory side.
// The "slave" modport is the execute stage's own view; "master" is the view of whoever drives it.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic            i_flush;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [XLEN-1:0] i_imm;
  logic            i_alusrc;
  logic [2:0]      i_alucrtl;
  logic [2:0]      i_branch_type;
  logic [4:0]      i_rd;
  logic            i_regwrite;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_alu_result;
  logic [XLEN-1:0] o_store_data;
  logic [4:0]      o_rd;
  logic            o_regwrite;
  logic            o_branch_taken;
  logic            o_redirect;
  logic [XLEN-1:0] o_branch_target;

  modport slave (
    input  i_valid, i_flush, i_pc, i_rs1_data, i_rs2_data, i_imm, i_alusrc,
           i_alucrtl, i_branch_type, i_rd, i_regwrite, i_ready,
    output o_ready, o_valid, o_alu_result, o_store_data, o_rd, o_regwrite,
           o_branch_taken, o_redirect, o_branch_target
  );

  modport master (
    output i_valid, i_flush, i_pc, i_rs1_data, i_rs2_data, i_imm, i_alusrc,
           i_alucrtl, i_branch_type, i_rd, i_regwrite, i_ready,
    input  o_ready, o_valid, o_alu_result, o_store_data, o_rd, o_regwrite,
           o_branch_taken, o_redirect, o_branch_target
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, dedicated branch comparators, one output register slot
// toward the memory stage, and a one-shot redirect pulse for taken branches.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  ex_stage_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_EMPTY, S_FRESH, S_HELD} state_t;

  state_t          state_q, state_d;
  logic            ready;
  logic            acc;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_d;
  logic            taken_d;
  logic            br_eq, br_lt_s, br_lt_u;

  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] store_q;
  logic [XLEN-1:0] target_q;
  logic [4:0]      rd_q;
  logic            regwrite_q;
  logic            taken_q;

  assign ready = (state_q == S_EMPTY) | bus.i_ready;
  assign acc   = bus.i_valid & ready & ~bus.i_flush;

  // ALU
  assign op_b = bus.i_alusrc ? bus.i_imm : bus.i_rs2_data;

  always_comb begin
    alu_d = '0;
    case (bus.i_alucrtl)
      3'b000:  alu_d = bus.i_rs1_data + op_b;
      3'b001:  alu_d = bus.i_rs1_data - op_b;
      3'b010:  alu_d = bus.i_rs1_data & op_b;
      3'b011:  alu_d = bus.i_rs1_data | op_b;
      3'b100:  alu_d = bus.i_rs1_data ^ op_b;
      3'b101:  alu_d = {{(XLEN-1){1'b0}}, ($signed(bus.i_rs1_data) < $signed(op_b))};
      3'b110:  alu_d = bus.i_rs1_data << op_b[SHW-1:0];
      default: alu_d = bus.i_rs1_data >> op_b[SHW-1:0];
    endcase
  end

  // Branch resolution always compares the register operands, never operand B.
  assign br_eq   = (bus.i_rs1_data == bus.i_rs2_data);
  assign br_lt_s = ($signed(bus.i_rs1_data) < $signed(bus.i_rs2_data));
  assign br_lt_u = (bus.i_rs1_data < bus.i_rs2_data);

  always_comb begin
    taken_d = 1'b0;
    case (bus.i_branch_type)
      3'b001:  taken_d = br_eq;
      3'b010:  taken_d = ~br_eq;
      3'b011:  taken_d = br_lt_s;
      3'b100:  taken_d = ~br_lt_s;
      3'b101:  taken_d = br_lt_u;
      3'b110:  taken_d = ~br_lt_u;
      default: taken_d = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: state_d = acc ? S_FRESH : S_EMPTY;
      S_FRESH, S_HELD: begin
        if (bus.i_flush)      state_d = S_EMPTY;
        else if (!bus.i_ready) state_d = S_HELD;
        else if (acc)          state_d = S_FRESH;
        else                   state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // FSM: outputs; flush suppresses the redirect of the instruction being killed.
  always_comb begin
    bus.o_ready    = ready;
    bus.o_valid    = (state_q != S_EMPTY);
    bus.o_redirect = (state_q == S_FRESH) & taken_q & ~bus.i_flush;
    bus.o_regwrite = (state_q != S_EMPTY) & regwrite_q;
  end

  // Output register; a load only ever happens on acc, otherwise contents hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      alu_q      <= '0;
      store_q    <= '0;
      target_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      taken_q    <= 1'b0;
    end else if (acc) begin
      alu_q      <= alu_d;
      store_q    <= bus.i_rs2_data;
      target_q   <= bus.i_pc + bus.i_imm;
      rd_q       <= bus.i_rd;
      regwrite_q <= bus.i_regwrite;
      taken_q    <= taken_d;
    end
  end

  assign bus.o_alu_result    = alu_q;
  assign bus.o_store_data    = store_q;
  assign bus.o_branch_target = target_q;
  assign bus.o_rd            = rd_q;
  assign bus.o_branch_taken  = taken_q;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a transaction-level model of the stage.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_if #(.XLEN(32)) bus ();

  ex_stage #(.XLEN(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Model: the single held instruction plus whether its first output cycle is still current.
  logic        m_valid = 1'b0;
  logic        m_fresh = 1'b0;
  logic [31:0] m_res = '0, m_store = '0, m_target = '0;
  logic [4:0]  m_rd = '0;
  logic        m_rw = 1'b0, m_taken = 1'b0;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b);
    case (bt)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return int'(a) < int'(b);
      3'd4: return !(int'(a) < int'(b));
      3'd5: return a < b;
      3'd6: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_fresh = 0; m_res = 0; m_store = 0; m_target = 0;
      m_rd = 0; m_rw = 0; m_taken = 0;
    end else begin
      if (bus.i_valid && (!m_valid || bus.i_ready) && !bus.i_flush) begin
        m_valid  = 1; m_fresh = 1;
        m_res    = ref_alu(bus.i_alucrtl, bus.i_rs1_data, bus.i_alusrc ? bus.i_imm : bus.i_rs2_data);
        m_store  = bus.i_rs2_data;
        m_target = bus.i_pc + bus.i_imm;
        m_rd     = bus.i_rd;
        m_rw     = bus.i_regwrite;
        m_taken  = ref_taken(bus.i_branch_type, bus.i_rs1_data, bus.i_rs2_data);
      end else if (m_valid && !bus.i_ready && !bus.i_flush) begin
        m_fresh = 0;
      end else begin
        m_valid = 0; m_fresh = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
      chk("o_ready", 32'(bus.o_ready), 32'(!m_valid || bus.i_ready));
      chk("o_redirect", 32'(bus.o_redirect), 32'(m_valid && m_fresh && m_taken && !bus.i_flush));
      chk("o_regwrite", 32'(bus.o_regwrite), 32'(m_valid && m_rw));
      if (m_valid) begin
        chk("o_alu_result", bus.o_alu_result, m_res);
        chk("o_store_data", bus.o_store_data, m_store);
        chk("o_branch_target", bus.o_branch_target, m_target);
        chk("o_rd", 32'(bus.o_rd), 32'(m_rd));
        chk("o_branch_taken", 32'(bus.o_branch_taken), 32'(m_taken));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] bt,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic src, input logic [31:0] pc);
    bus.i_valid = v; bus.i_alucrtl = op; bus.i_branch_type = bt;
    bus.i_rs1_data = a; bus.i_rs2_data = b; bus.i_imm = imm; bus.i_alusrc = src; bus.i_pc = pc;
    bus.i_rd = 5'(a[4:0] ^ b[4:0]); bus.i_regwrite = (bt == 3'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_redirect"}, 32'(bus.o_redirect), 32'd0);
    chk({tag, "_taken"}, 32'(bus.o_branch_taken), 32'd0);
    chk({tag, "_regwrite"}, 32'(bus.o_regwrite), 32'd0);
    chk({tag, "_alu"}, bus.o_alu_result, 32'd0);
    chk({tag, "_store"}, bus.o_store_data, 32'd0);
    chk({tag, "_target"}, bus.o_branch_target, 32'd0);
    chk({tag, "_rd"}, 32'(bus.o_rd), 32'd0);
  endtask

  logic [31:0] alu_exp [9];
  logic [2:0]  br_types [4];
  logic        br_exp [4];
  logic [31:0] held_res;

  initial begin
    alu_exp = '{32'hFFFF_FFF4, 32'hFFFF_FFEC, 32'h0000_0000, 32'hFFFF_FFF4, 32'hFFFF_FFF4,
                32'h0000_0001, 32'hFFFF_FF00, 32'h0FFF_FFFF, 32'hFFFF_FF00};
    br_types = '{3'd3, 3'd6, 3'd5, 3'd4};
    br_exp   = '{1'b1, 1'b1, 1'b0, 1'b0};
    bus.i_ready = 1'b1; bus.i_flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    chk_zero_outputs("reset");
    rst = 1'b0;
    cyc();

    // ALU sweep, back-to-back; last entry uses the immediate 0x24 as a shift of 4.
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drive(1, 3'(k), 0, 32'hFFFF_FFF0, 32'h4, 32'h0, 0, 32'h40);
      else       drive(1, 3'd6, 0, 32'hFFFF_FFF0, 32'h4, 32'h24, 1, 32'h40);
      cyc();
      chk("alu_sweep", bus.o_alu_result, alu_exp[k]);
      $display("alu op %0d -> %h", k, bus.o_alu_result);
    end

    // Branch signedness, target wraps 0x100 + (-8).
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, br_types[k], 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 1, 32'h100);
      cyc();
      chk("br_taken", 32'(bus.o_branch_taken), 32'(br_exp[k]));
      chk("br_redirect", 32'(bus.o_redirect), 32'(br_exp[k]));
      chk("br_target", bus.o_branch_target, 32'h0000_00F8);
      $display("branch type %0d -> taken %0b", br_types[k], bus.o_branch_taken);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    // Stall: taken BEQ, three cycles of backpressure.
    drive(1, 0, 3'd1, 32'h5, 32'h5, 32'h20, 1, 32'h200);
    cyc();
    bus.i_valid = 0; bus.i_ready = 0;
    #1;
    chk("stall_redirect_first", 32'(bus.o_redirect), 32'd1);
    chk("stall_ready", 32'(bus.o_ready), 32'd0);
    held_res = bus.o_alu_result;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("stall_redirect_held", 32'(bus.o_redirect), 32'd0);
      chk("stall_ready_held", 32'(bus.o_ready), 32'd0);
      chk("stall_result_stable", bus.o_alu_result, held_res);
    end
    cyc();
    bus.i_ready = 1;
    #1;
    chk("stall_release_ready", 32'(bus.o_ready), 32'd1);
    cyc();

    // Flush priority over redirect and over accept.
    drive(1, 0, 3'd2, 32'h1, 32'h2, 32'h40, 1, 32'h300);
    cyc();
    drive(1, 0, 0, 32'h7, 32'h8, 32'h0, 0, 32'h304);
    bus.i_flush = 1;
    #1;
    chk("flush_redirect", 32'(bus.o_redirect), 32'd0);
    cyc();
    chk("flush_valid", 32'(bus.o_valid), 32'd0);
    bus.i_flush = 0; bus.i_valid = 0;
    cyc();

    // Reset while HELD with a taken branch loaded.
    drive(1, 0, 3'd1, 32'h9, 32'h9, 32'h10, 1, 32'h400);
    cyc();
    bus.i_valid = 0; bus.i_ready = 0;
    cyc();
    rst = 1;
    #1;
    chk_zero_outputs("midreset");
    cyc();
    rst = 0; bus.i_ready = 1;
    for (int k = 0; k < 3; k++) cyc();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            a, b, $urandom, 1'($urandom_range(0, 1)), $urandom);
      bus.i_ready = ($urandom_range(0, 9) < 7);
      bus.i_flush = ($urandom_range(0, 19) == 0);
      cyc();
    end
    bus.i_valid = 0; bus.i_flush = 0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
